// File: rtl/seg_pkg.sv
// seg_pkg: segment bit positions, font patterns and FSM states shared by the
// message scroller and its font ROM (patterns are built from the bit positions).
package seg_pkg;
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] M_A  = 8'(1 << SEG_A);
  localparam logic [7:0] M_B  = 8'(1 << SEG_B);
  localparam logic [7:0] M_C  = 8'(1 << SEG_C);
  localparam logic [7:0] M_D  = 8'(1 << SEG_D);
  localparam logic [7:0] M_E  = 8'(1 << SEG_E);
  localparam logic [7:0] M_F  = 8'(1 << SEG_F);
  localparam logic [7:0] M_G  = 8'(1 << SEG_G);
  localparam logic [7:0] M_DP = 8'(1 << SEG_DP);

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] FONT_0 = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [7:0] FONT_1 = M_B | M_C;
  localparam logic [7:0] FONT_2 = M_A | M_B | M_D | M_E | M_G;
  localparam logic [7:0] FONT_3 = M_A | M_B | M_C | M_D | M_G;
  localparam logic [7:0] FONT_4 = M_B | M_C | M_F | M_G;
  localparam logic [7:0] FONT_5 = M_A | M_C | M_D | M_F | M_G;
  localparam logic [7:0] FONT_6 = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [7:0] FONT_7 = M_A | M_B | M_C;
  localparam logic [7:0] FONT_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [7:0] FONT_9 = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [7:0] FONT_A = M_A | M_B | M_C | M_E | M_F | M_G;
  localparam logic [7:0] FONT_B = M_C | M_D | M_E | M_F | M_G;
  localparam logic [7:0] FONT_C = M_A | M_D | M_E | M_F;
  localparam logic [7:0] FONT_D = M_B | M_C | M_D | M_E | M_G;
  localparam logic [7:0] FONT_E = M_A | M_D | M_E | M_F | M_G;
  localparam logic [7:0] FONT_F = M_A | M_E | M_F | M_G;
  localparam logic [7:0] FONT_H = M_B | M_C | M_E | M_F | M_G;
  localparam logic [7:0] FONT_L = M_D | M_E | M_F;
  localparam logic [7:0] FONT_O = FONT_0;
  localparam logic [7:0] FONT_P = M_A | M_B | M_E | M_F | M_G;
  localparam logic [7:0] FONT_S = FONT_5;
  localparam logic [7:0] FONT_U = M_B | M_C | M_D | M_E | M_F;
  localparam logic [7:0] FONT_MINUS = M_G;
  localparam logic [7:0] FONT_DOT   = M_DP;
  localparam logic [7:0] FONT_SPACE = SEG_BLANK;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;
endpackage

// File: rtl/seg_font_rom.sv
// seg_font_rom: ASCII -> 7-segment pattern, lowercase folded to uppercase.
// Purely combinational, no flow control; unknown characters render blank.
module seg_font_rom
  import seg_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [7:0] seg
);
  logic [7:0] ch;

  always_comb begin
    ch  = (ascii >= 8'h61 && ascii <= 8'h7A) ? ascii - 8'h20 : ascii;
    seg = SEG_BLANK;
    case (ch)
      "0": seg = FONT_0;
      "1": seg = FONT_1;
      "2": seg = FONT_2;
      "3": seg = FONT_3;
      "4": seg = FONT_4;
      "5": seg = FONT_5;
      "6": seg = FONT_6;
      "7": seg = FONT_7;
      "8": seg = FONT_8;
      "9": seg = FONT_9;
      "A": seg = FONT_A;
      "B": seg = FONT_B;
      "C": seg = FONT_C;
      "D": seg = FONT_D;
      "E": seg = FONT_E;
      "F": seg = FONT_F;
      "H": seg = FONT_H;
      "L": seg = FONT_L;
      "O": seg = FONT_O;
      "P": seg = FONT_P;
      "S": seg = FONT_S;
      "U": seg = FONT_U;
      "-": seg = FONT_MINUS;
      ".": seg = FONT_DOT;
      " ": seg = FONT_SPACE;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: message buffer with a scrolling DIGITS-wide window; 1-cycle digit_idx->seg_out.
// Backpressure: wr_ready low while a committed message is shown or while clear is asserted.
module seg_msg_scroller
  import seg_pkg::*;
#(
  parameter int MSG_DEPTH = 16,
  parameter int DIGITS    = 10,
  parameter int TICK_DIV  = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       wr_last,
  input  logic       clear,
  input  logic       scroll_en,
  input  logic [3:0] digit_idx,
  output logic [7:0] seg_out,
  output logic [4:0] msg_len
);
  localparam int AW  = $clog2(MSG_DEPTH);
  localparam int PSW = $clog2(TICK_DIV);
  localparam logic [AW-1:0]  LAST_IDX = AW'(MSG_DEPTH - 1);
  localparam logic [PSW-1:0] PS_MAX   = PSW'(TICK_DIV - 1);
  localparam logic [4:0]     DIG_LEN  = 5'(DIGITS);

  state_t         state, state_nxt;
  logic [AW-1:0]  wr_ptr;
  logic [4:0]     offset;
  logic [4:0]     offset_inc;
  logic [PSW-1:0] prescaler;
  logic [7:0]     msg_buf [MSG_DEPTH];
  logic           wr_acc, last_wr, step_en, rd_en;
  logic [5:0]     rd_sum;
  logic [AW-1:0]  rd_idx;
  logic [7:0]     rd_char, font_seg;

  // The buffer's final slot always ends the message, even without wr_last.
  assign last_wr = wr_last || (wr_ptr == LAST_IDX);
  assign wr_acc  = wr_valid && wr_ready;

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    case (state)
      IDLE, LOAD: begin
        wr_ready = !clear;
        if (wr_valid) state_nxt = last_wr ? SHOW : LOAD;
      end
      SHOW: ;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign step_en    = (state == SHOW) && scroll_en && (msg_len > DIG_LEN);
  assign offset_inc = offset + 5'd1;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr    <= '0;
      msg_len   <= '0;
      offset    <= '0;
      prescaler <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (last_wr) begin
        msg_len   <= 5'(wr_ptr) + 5'd1;
        offset    <= '0;
        prescaler <= '0;
      end
    end else if (step_en) begin
      if (prescaler == PS_MAX) begin
        prescaler <= '0;
        offset    <= (offset_inc == msg_len) ? 5'd0 : offset_inc;
      end else begin
        prescaler <= prescaler + PSW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) msg_buf[wr_ptr] <= wr_char;
  end

  // offset < msg_len and digit_idx < msg_len whenever the read is enabled,
  // so one conditional subtraction wraps the window.
  assign rd_sum  = 6'(offset) + 6'(digit_idx);
  assign rd_idx  = AW'((rd_sum >= 6'(msg_len)) ? rd_sum - 6'(msg_len) : rd_sum);
  assign rd_char = msg_buf[rd_idx];
  assign rd_en   = (state == SHOW) && (digit_idx < 4'(DIGITS)) &&
                   ((msg_len > DIG_LEN) || (5'(digit_idx) < msg_len));

  seg_font_rom u_font (
    .ascii (rd_char),
    .seg   (font_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) seg_out <= SEG_BLANK;
    else                 seg_out <= rd_en ? font_seg : SEG_BLANK;
  end
endmodule

// File: tb/tb_seg_msg_scroller.sv
// Bench for seg_msg_scroller: scenario tasks drive stimulus; seg_out reads are
// checked by a scoreboard that pops one expectation per probe, one cycle later.
module tb_seg_msg_scroller;
  localparam int DEPTH = 16;
  localparam int DIGITS = 10;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_char = 8'h00;
  logic       wr_last = 1'b0;
  logic       clear = 1'b0;
  logic       scroll_en = 1'b0;
  logic [3:0] digit_idx = 4'd0;
  logic [7:0] seg_out;
  logic [4:0] msg_len;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         idx_q[$];
  logic [7:0] mon_e;
  int         mon_d;

  logic [7:0] m_buf [DEPTH];
  int         m_len = 0;
  int         m_off = 0;
  bit         m_show = 1'b0;
  logic [7:0] want [DIGITS];

  seg_msg_scroller #(.MSG_DEPTH(DEPTH), .DIGITS(DIGITS), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_char   (wr_char),
    .wr_last   (wr_last),
    .clear     (clear),
    .scroll_en (scroll_en),
    .digit_idx (digit_idx),
    .seg_out   (seg_out),
    .msg_len   (msg_len)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: an expectation pushed in cycle n is checked just after edge n+1.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_d = idx_q.pop_front();
      n_cmp++;
      if (seg_out !== mon_e) begin
        n_err++;
        $display("FAIL seg_out digit %0d: got %02h want %02h", mon_d, seg_out, mon_e);
      end
    end
  end

  function automatic logic [7:0] font(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "0", "O": return 8'hFC;
      "1": return 8'h60;
      "2": return 8'hDA;
      "3": return 8'hF2;
      "4": return 8'h66;
      "5", "S": return 8'hB6;
      "6": return 8'hBE;
      "7": return 8'hE0;
      "8": return 8'hFE;
      "9": return 8'hF6;
      "A": return 8'hEE;
      "B": return 8'h3E;
      "C": return 8'h9C;
      "D": return 8'h7A;
      "E": return 8'h9E;
      "F": return 8'h8E;
      "H": return 8'h6E;
      "L": return 8'h1C;
      "P": return 8'hCE;
      "U": return 8'h7C;
      "-": return 8'h02;
      ".": return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    if (!m_show || d >= DIGITS) return 8'h00;
    if (m_len <= DIGITS && d >= m_len) return 8'h00;
    return font(m_buf[(m_off + d) % m_len]);
  endfunction

  task automatic model_window();
    for (int d = 0; d < DIGITS; d++) want[d] = exp_seg(d);
  endtask

  task automatic push_probe(input int d, input logic [7:0] e);
    digit_idx = 4'(d);
    exp_q.push_back(e);
    idx_q.push_back(d);
  endtask

  task automatic sweep();
    for (int d = 0; d < DIGITS; d++) begin
      @(negedge clk);
      push_probe(d, want[d]);
    end
    @(negedge clk);
    push_probe(12, 8'h00);
    @(negedge clk);
    digit_idx = 4'd0;
  endtask

  task automatic probe(input int d, input logic [7:0] e);
    @(negedge clk);
    push_probe(d, e);
    @(negedge clk);
  endtask

  task automatic load_msg(input string s, input bit with_last);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_char  = s[i];
      wr_last  = with_last && (i == s.len() - 1);
      m_buf[i] = s[i];
      #1;
      n_cmp++;
      if (wr_ready !== 1'b1) begin
        n_err++;
        $display("FAIL wr_ready during load char %0d: got %b want 1", i, wr_ready);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (with_last) begin
      m_len = s.len(); m_off = 0; m_show = 1'b1;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL wr_ready under clear: got %b want 0", wr_ready);
    end
    @(negedge clk);
    clear = 1'b0;
    m_show = 1'b0; m_len = 0; m_off = 0;
    #1;
    n_cmp++;
    if (msg_len !== 5'd0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL after clear: msg_len=%0d wr_ready=%b want 0/1", msg_len, wr_ready);
    end
  endtask

  task automatic step(input int n);
    @(negedge clk);
    scroll_en = 1'b1;
    repeat (n * TD) @(negedge clk);
    scroll_en = 1'b0;
    m_off = (m_off + n) % m_len;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (seg_out !== 8'h00 || msg_len !== 5'd0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: seg_out=%02h msg_len=%0d wr_ready=%b want 00/0/1",
               seg_out, msg_len, wr_ready);
    end
    rst_n = 1'b1;
    model_window();
    sweep();
  endtask

  task automatic test_static_window();
    scroll_en = 1'b1;
    load_msg("POSOCO2000", 1'b1);
    scroll_en = 1'b0;
    n_cmp++;
    if (msg_len !== 5'd10 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL static load: msg_len=%0d wr_ready=%b want 10/0", msg_len, wr_ready);
    end
    want = '{8'hCE, 8'hFC, 8'hB6, 8'hFC, 8'h9C, 8'hFC, 8'hDA, 8'hFC, 8'hFC, 8'hFC};
    sweep();
    // Exactly-DIGITS message must not scroll.
    scroll_en = 1'b1;
    for (int c = 0; c < 3 * TD; c++) begin
      @(negedge clk);
      push_probe(c % DIGITS, want[c % DIGITS]);
    end
    @(negedge clk);
    scroll_en = 1'b0;
  endtask

  task automatic test_short_msg();
    do_clear();
    load_msg("C-2", 1'b1);
    want = '{8'h9C, 8'h02, 8'hDA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sweep();
  endtask

  task automatic test_scroll();
    do_clear();
    scroll_en = 1'b1;
    load_msg("POSOCO2000 -", 1'b1);
    scroll_en = 1'b0;
    model_window();
    sweep();
    step(1);
    probe(0, 8'hFC);
    probe(9, 8'h00);
    model_window();
    sweep();
    step(1);
    probe(9, 8'h02);
    step(10);
    want = '{8'hCE, 8'hFC, 8'hB6, 8'hFC, 8'h9C, 8'hFC, 8'hDA, 8'hFC, 8'hFC, 8'hFC};
    sweep();
    // Pause mid-prescale: the partial count must survive the hold.
    @(negedge clk);
    scroll_en = 1'b1;
    repeat (2) @(negedge clk);
    scroll_en = 1'b0;
    repeat (20) @(negedge clk);
    model_window();
    sweep();
    scroll_en = 1'b1;
    repeat (2) @(negedge clk);
    scroll_en = 1'b0;
    m_off = (m_off + 1) % m_len;
    model_window();
    sweep();
  endtask

  task automatic test_forced_last();
    string s;
    s = "0123456789ABCDEF8";
    do_clear();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_char  = s[i];
      wr_last  = 1'b0;
      if (i < DEPTH) m_buf[i] = s[i];
      #1;
      n_cmp++;
      if (wr_ready !== (i < DEPTH)) begin
        n_err++;
        $display("FAIL stream wr_ready char %0d: got %b want %b", i, wr_ready, (i < DEPTH));
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    m_len = DEPTH; m_off = 0; m_show = 1'b1;
    n_cmp++;
    if (msg_len !== 5'd16 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL forced last: msg_len=%0d wr_ready=%b want 16/0", msg_len, wr_ready);
    end
    model_window();
    sweep();
    step(10);
    model_window();
    sweep();
  endtask

  task automatic test_clear_and_reset();
    do_clear();
    load_msg("12", 1'b0);
    @(negedge clk);
    wr_valid = 1'b1; wr_char = "9"; wr_last = 1'b1; clear = 1'b1;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL clear with write: wr_ready=%b want 0", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0; clear = 1'b0;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1 || msg_len !== 5'd0) begin
      n_err++;
      $display("FAIL post clear: wr_ready=%b msg_len=%0d want 1/0", wr_ready, msg_len);
    end
    m_show = 1'b0; m_len = 0;
    model_window();
    sweep();
    load_msg("7", 1'b1);
    n_cmp++;
    if (msg_len !== 5'd1) begin
      n_err++; $display("FAIL single char: msg_len=%0d want 1", msg_len);
    end
    probe(0, 8'hE0);
    probe(1, 8'h00);
    // Clear while a lit digit is being read.
    @(negedge clk);
    digit_idx = 4'd0;
    clear = 1'b1;
    exp_q.push_back(8'h00); idx_q.push_back(0);
    @(negedge clk);
    clear = 1'b0;
    m_show = 1'b0; m_len = 0;
    // Reset in the middle of scrolling.
    load_msg("POSOCO2000 -", 1'b1);
    step(1);
    @(negedge clk);
    scroll_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    push_probe(0, 8'h00);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (seg_out !== 8'h00 || msg_len !== 5'd0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid-scroll reset: seg_out=%02h msg_len=%0d wr_ready=%b want 00/0/1",
               seg_out, msg_len, wr_ready);
    end
    rst_n = 1'b1;
    scroll_en = 1'b0;
    m_show = 1'b0; m_len = 0; m_off = 0;
    model_window();
    sweep();
    load_msg("C-2", 1'b1);
    model_window();
    sweep();
  endtask

  initial begin
    test_reset();
    test_static_window();
    test_short_msg();
    test_scroll();
    test_forced_last();
    test_clear_and_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
